// File: rtl/bsk_prd_master.sv
// Polling master for one PRD command board on its 16-bit async read/write bus.
// Each poll: read W0, W1, write indication and test-enable, read password/version.
module bsk_prd_master #(
    parameter logic [3:0]  CS_ADDR    = 4'b1011,
    parameter logic [7:0]  PASSWORD   = 8'hA4,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned POLL_DIV   = 2000
) (
    input  logic        clk,
    input  logic        iRes,
    inout  wire  [15:0] bD,
    output logic        oRd,
    output logic        oWr,
    output logic [1:0]  oA,
    output logic [3:0]  oCS,
    input  logic        iEn,
    input  logic [15:0] iComInd,
    input  logic        iTestEn,
    output logic [15:0] oCom,
    output logic        oComErr,
    output logic        oPassErr,
    output logic [6:0]  oVersion,
    output logic        oTestEn,
    output logic        oValid,
    output logic        oBusy
);

    localparam int unsigned PW = $clog2(POLL_DIV);
    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_DIV - 1);
    localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);

    typedef enum logic [1:0] {IDLE, TXN, DONE} state_t;
    typedef enum logic [1:0] {SETUP, STROBE, HOLD} phase_t;

    state_t        state;
    phase_t        phase;
    logic [2:0]    idx;
    logic [7:0]    cnt;
    logic [PW-1:0] poll_cnt;
    logic          pending;
    logic [15:0]   com_ind_q;
    logic          te_q;
    logic [15:0]   w0, w1, w3;
    logic          drv;
    logic [15:0]   dout;

    logic          tick, start, cur_wr, com_ok;
    logic [2:0]    idx_nxt;
    logic [15:0]   com_dec;

    function automatic logic nib_ok(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction

    function automatic logic is_wr(input logic [2:0] i);
        return (i == 3'd2) || (i == 3'd3);
    endfunction

    function automatic logic [1:0] addr_of(input logic [2:0] i);
        case (i)
            3'd0:    return 2'b00;
            3'd1:    return 2'b01;
            3'd2:    return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    assign tick    = (poll_cnt == '0);
    assign start   = (state == IDLE) && pending && iEn;
    assign cur_wr  = is_wr(idx);
    assign idx_nxt = idx + 3'd1;
    assign com_ok  = nib_ok(w0[15:8]) & nib_ok(w0[7:0]) & nib_ok(w1[15:8]) & nib_ok(w1[7:0]);
    assign com_dec = {w1[11:8], w1[3:0], w0[11:8], w0[3:0]};

    assign bD = drv ? dout : 'z;

    always_ff @(posedge clk) begin
        if (!iRes) begin
            state     <= IDLE;
            phase     <= SETUP;
            idx       <= '0;
            cnt       <= '0;
            poll_cnt  <= POLL_MAX;
            pending   <= 1'b0;
            com_ind_q <= '0;
            te_q      <= 1'b0;
            w0        <= '0;
            w1        <= '0;
            w3        <= '0;
            drv       <= 1'b0;
            dout      <= '0;
            oRd       <= 1'b1;
            oWr       <= 1'b1;
            oA        <= '0;
            oCS       <= ~CS_ADDR;
            oCom      <= '0;
            oComErr   <= 1'b0;
            oPassErr  <= 1'b0;
            oVersion  <= '0;
            oTestEn   <= 1'b0;
            oValid    <= 1'b0;
            oBusy     <= 1'b0;
        end else begin
            oValid   <= 1'b0;
            poll_cnt <= tick ? POLL_MAX : poll_cnt - PW'(1);
            // a tick coinciding with the start of a poll is kept for the next one
            pending  <= tick | (pending & ~start);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= TXN;
                        phase     <= SETUP;
                        idx       <= '0;
                        cnt       <= '0;
                        com_ind_q <= iComInd;
                        te_q      <= iTestEn;
                        oBusy     <= 1'b1;
                        oCS       <= CS_ADDR;
                        oA        <= addr_of(3'd0);
                        drv       <= 1'b0;
                    end
                end
                TXN: begin
                    unique case (phase)
                        SETUP: begin
                            if (cnt == SETUP_LAST) begin
                                cnt   <= '0;
                                phase <= STROBE;
                                if (cur_wr) oWr <= 1'b0;
                                else        oRd <= 1'b0;
                            end else begin
                                cnt <= cnt + 8'd1;
                            end
                        end
                        STROBE: begin
                            if (cnt == STROBE_LAST) begin
                                cnt   <= '0;
                                phase <= HOLD;
                                oRd   <= 1'b1;
                                oWr   <= 1'b1;
                                if (!cur_wr) begin
                                    case (idx)
                                        3'd0:    w0 <= bD;
                                        3'd1:    w1 <= bD;
                                        default: w3 <= bD;
                                    endcase
                                end
                            end else begin
                                cnt <= cnt + 8'd1;
                            end
                        end
                        HOLD: begin
                            if (cnt == HOLD_LAST) begin
                                cnt <= '0;
                                if (idx == 3'd4) begin
                                    state    <= DONE;
                                    oValid   <= 1'b1;
                                    oCS      <= ~CS_ADDR;
                                    oA       <= '0;
                                    drv      <= 1'b0;
                                    oComErr  <= ~com_ok;
                                    if (com_ok) oCom <= com_dec;
                                    oPassErr <= (w3[15:8] != PASSWORD);
                                    oVersion <= w3[7:1];
                                    oTestEn  <= w3[0];
                                end else begin
                                    // next transaction's address and write data set up here
                                    idx   <= idx_nxt;
                                    phase <= SETUP;
                                    oA    <= addr_of(idx_nxt);
                                    drv   <= is_wr(idx_nxt);
                                    dout  <= (idx_nxt == 3'd2) ? com_ind_q : {15'b0, te_q};
                                end
                            end else begin
                                cnt <= cnt + 8'd1;
                            end
                        end
                        default: phase <= SETUP;
                    endcase
                end
                DONE: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bsk_prd_master.sv
// Scoreboard bench for bsk_prd_master with a behavioural PRD board on the bus.
module tb_bsk_prd_master;

    localparam int unsigned POLL_DIV = 64;
    localparam logic [15:0] PROBE    = 16'h1248;

    typedef struct {
        logic [15:0] com;
        logic        comerr;
        logic        passerr;
        logic [6:0]  ver;
        logic        te;
    } res_t;

    logic        clk = 1'b0;
    logic        iRes = 1'b0;
    logic        iEn = 1'b0;
    logic        iTestEn = 1'b0;
    logic [15:0] iComInd = '0;
    wire  [15:0] bD;
    logic        oRd, oWr, oComErr, oPassErr, oTestEn, oValid, oBusy;
    logic [1:0]  oA;
    logic [3:0]  oCS;
    logic [15:0] oCom;
    logic [6:0]  oVersion;

    logic [15:0] s_w0, s_w1;
    logic [7:0]  s_pass;
    logic [6:0]  s_ver;
    logic        s_te;

    res_t        rq[$];
    logic [15:0] wq[$];
    int          errors = 0;
    int          checks = 0;
    int          rel = 0;
    int          bc = 0;
    int          starts = 0;
    int          last_start = 0;
    logic [15:0] cur_w = '0;

    always #5 clk = ~clk;

    bsk_prd_master #(
        .CS_ADDR(4'b1011), .PASSWORD(8'hA4), .SETUP_CYC(1), .STROBE_CYC(4),
        .HOLD_CYC(1), .POLL_DIV(POLL_DIV)
    ) dut (
        .clk(clk), .iRes(iRes), .bD(bD), .oRd(oRd), .oWr(oWr), .oA(oA), .oCS(oCS),
        .iEn(iEn), .iComInd(iComInd), .iTestEn(iTestEn), .oCom(oCom),
        .oComErr(oComErr), .oPassErr(oPassErr), .oVersion(oVersion),
        .oTestEn(oTestEn), .oValid(oValid), .oBusy(oBusy)
    );

    // Board answers reads; the bench holds a known pattern while the master is idle
    wire        slave_en   = (oCS == 4'b1011) && !oRd;
    wire [15:0] slave_data = (oA == 2'b00) ? s_w0 : (oA == 2'b01) ? s_w1 : {s_pass, s_ver, s_te};
    assign bD = slave_en ? slave_data : 16'hzzzz;
    assign bD = !oBusy ? PROBE : 16'hzzzz;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_addr(input int k);
        case (k)
            0: return 2'b00;
            1: return 2'b01;
            2: return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        if (oCS == 4'b1011 && !oWr && oA == 2'b11) s_te = bD[0];
    end

    // Bus-timing monitor: cycle bc of a busy period, 6 cycles per transaction
    initial forever begin
        int k, p;
        logic wr, strobe;
        @(negedge clk);
        if (!iRes) rel = 0;
        else rel++;
        if (oBusy) begin
            if (bc == 0) begin
                starts++;
                last_start = rel;
            end
            k = bc / 6;
            p = bc % 6;
            if (bc < 30) begin
                wr = (k == 2) || (k == 3);
                strobe = (p >= 1) && (p <= 4);
                chk("rd_strobe", oRd, !(strobe && !wr));
                chk("wr_strobe", oWr, !(strobe && wr));
                chk("cs_active", oCS, 4'b1011);
                chk("addr", oA, exp_addr(k));
                chk("valid_early", oValid, 0);
                if (wr) begin
                    if (p == 0) begin
                        if (wq.size() == 0) begin
                            chk("write_unexpected", 1, 0);
                            cur_w = 16'hxxxx;
                        end else begin
                            cur_w = wq.pop_front();
                        end
                    end
                    chk("write_data", bD, cur_w);
                end
            end else if (bc == 30) begin
                chk("done_valid", oValid, 1);
                chk("done_cs", oCS, 4'b0100);
                chk("done_strobes", {oRd, oWr}, 2'b11);
            end else begin
                chk("busy_overrun", bc, 30);
            end
            bc++;
        end else begin
            bc = 0;
        end
    end

    // Result monitor
    initial forever begin
        res_t e;
        @(negedge clk);
        if (iRes && oValid) begin
            if (rq.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = rq.pop_front();
                chk("com", oCom, e.com);
                chk("com_err", oComErr, e.comerr);
                chk("pass_err", oPassErr, e.passerr);
                chk("version", oVersion, e.ver);
                chk("test_en", oTestEn, e.te);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_poll(input int n, input int exp_start);
        int b;
        b = 0;
        while (starts < n && b < 300) begin step(); b++; end
        chk("poll_count", starts, n);
        chk("poll_start", last_start, exp_start);
        b = 0;
        while (oBusy && b < 50) begin step(); b++; end
        chk("poll_end", oBusy, 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rd"}, oRd, 1);
        chk({tag, "_wr"}, oWr, 1);
        chk({tag, "_a"}, oA, 0);
        chk({tag, "_cs"}, oCS, 4'b0100);
        chk({tag, "_bus"}, bD, PROBE);
        chk({tag, "_com"}, oCom, 0);
        chk({tag, "_flags"}, {oComErr, oPassErr, oTestEn}, 0);
        chk({tag, "_ver"}, oVersion, 0);
        chk({tag, "_valid"}, oValid, 0);
        chk({tag, "_busy"}, oBusy, 0);
    endtask

    initial begin
        int b, en_at;
        s_w0 = 16'hC3B4; s_w1 = 16'hE1D2; s_pass = 8'hA4; s_ver = 7'h25; s_te = 1'b0;
        repeat (3) step();
        chk_idle_outputs("reset");

        // Tick after POLL_DIV edges from release, poll starts one edge later
        iEn = 1'b1; iComInd = 16'hA5A5; iTestEn = 1'b1;
        rq.push_back('{16'h1234, 1'b0, 1'b0, 7'h25, 1'b1});
        wq.push_back(16'hA5A5); wq.push_back(16'h0001);
        iRes = 1'b1;
        run_poll(1, 65);

        s_w1 = 16'hE1D3; iComInd = 16'h0F0F; iTestEn = 1'b0;
        rq.push_back('{16'h1234, 1'b1, 1'b0, 7'h25, 1'b0});
        wq.push_back(16'h0F0F); wq.push_back(16'h0000);
        run_poll(2, 129);

        s_w1 = 16'hE1D2; s_w0 = 16'h5AE1; s_pass = 8'h55; iComInd = 16'h8001; iTestEn = 1'b1;
        rq.push_back('{16'h12A1, 1'b0, 1'b1, 7'h25, 1'b1});
        wq.push_back(16'h8001); wq.push_back(16'h0001);
        run_poll(3, 193);

        // Reset while transaction 2 is strobing
        s_pass = 8'hA4; iComInd = 16'h3C3C;
        wq.push_back(16'h3C3C);
        b = 0;
        while (bc < 15 && b < 300) begin step(); b++; end
        chk("reach_txn2_strobe", bc, 15);
        iRes = 1'b0;
        step();
        chk_idle_outputs("midreset");
        iComInd = 16'h0102;
        rq.push_back('{16'h12A1, 1'b0, 1'b0, 7'h25, 1'b1});
        wq.push_back(16'h0102); wq.push_back(16'h0001);
        iRes = 1'b1;
        run_poll(5, 65);

        // Ticks at 128, 192, 256 arrive while disabled; only one poll may result
        iEn = 1'b0;
        b = 0;
        while (rel < 269 && b < 400) begin step(); b++; end
        chk("disabled_no_poll", starts, 5);
        en_at = rel;
        for (int i = 0; i < 2; i++) begin
            rq.push_back('{16'h12A1, 1'b0, 1'b0, 7'h25, 1'b1});
            wq.push_back(16'h0102); wq.push_back(16'h0001);
        end
        iEn = 1'b1;
        run_poll(6, en_at + 1);
        b = 0;
        while (rel < 319 && b < 100) begin step(); b++; end
        chk("single_pending_poll", starts, 6);
        run_poll(7, 321);

        repeat (5) step();
        chk("result_queue_empty", rq.size(), 0);
        chk("write_queue_empty", wq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
